// File: rtl/addr_reg.sv
// 16-bit loadable, incrementing address register with a tri-state bus output.
// Built from four 4-bit counter slices joined by a ripple-carry enable chain.
module addr_reg (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD_bar,
    input  logic        INC,
    input  logic        ASSERT_bar,
    input  logic [15:0] BUS_in,
    output logic [15:0] BUS_out
);

    localparam int unsigned NSLICE = 4;

    // carry[n] enables slice n: INC for slice 0, else all lower slices at 0xF
    logic [NSLICE-1:0] carry;
    logic [15:0]       addr_q;

    assign carry[0] = INC;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            logic [3:0] nib_q;
            logic [3:0] nib_d;

            always_comb begin
                nib_d = nib_q;
                if (!LOAD_bar) begin
                    nib_d = BUS_in[gi*4 +: 4];
                end else if (carry[gi]) begin
                    nib_d = nib_q + 4'd1;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    nib_q <= 4'h0;
                end else begin
                    nib_q <= nib_d;
                end
            end

            if (gi < NSLICE - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & (nib_q == 4'hF);
            end

            assign addr_q[gi*4 +: 4] = nib_q;
        end
    endgenerate

    // Output enable is purely combinational and never touches the register.
    assign BUS_out = ASSERT_bar ? 16'hzzzz : addr_q;

endmodule

// File: tb/tb_addr_reg.sv
// Self-checking bench for addr_reg: vector table, hand-built reset/tri-state
// sequences, then randomized traffic against an arithmetic reference model.
module tb_addr_reg;

    logic        clk;
    logic        rst;
    logic        load_bar;
    logic        inc;
    logic        assert_bar;
    logic [15:0] bus_in;
    wire  [15:0] bus_w;

    // Bench-side bus driver: when the DUT floats, the bus shows this value.
    logic        drv_en;
    logic [15:0] drv_val;
    assign bus_w = drv_en ? drv_val : 16'hzzzz;

    int n_checks;
    int n_pass;
    logic [15:0] model_q;

    addr_reg dut (
        .CLK        (clk),
        .RST        (rst),
        .LOAD_bar   (load_bar),
        .INC        (inc),
        .ASSERT_bar (assert_bar),
        .BUS_in     (bus_in),
        .BUS_out    (bus_w)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        lb;
        logic        inc;
        logic [15:0] bin;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive controls, take one rising edge, then update the reference model.
    task automatic apply(input logic lb, input logic i, input logic [15:0] bin);
        load_bar = lb;
        inc      = i;
        bus_in   = bin;
        @(posedge clk);
        #1;
        if (!lb)    model_q = bin;
        else if (i) model_q = model_q + 16'd1;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        load_bar   = 1'b1;
        inc        = 1'b0;
        assert_bar = 1'b0;
        bus_in     = 16'h0000;
        drv_en     = 1'b0;
        drv_val    = 16'h0000;
        model_q    = 16'h0000;

        #5;
        check("reset_state", bus_w, 16'h0000);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("hold_after_reset", bus_w, 16'h0000);

        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0001, "count_1"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0002, "count_2"});
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h0002, "hold"});
        vecs.push_back('{1'b0, 1'b1, 16'h8FFF, 16'h8FFF, "load_beats_inc"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h9000, "ripple_8fff"});
        vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, "load_ffff"});
        vecs.push_back('{1'b1, 1'b1, 16'h1234, 16'h0000, "wrap"});
        vecs.push_back('{1'b0, 1'b0, 16'h00FF, 16'h00FF, "load_00ff"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0100, "ripple_00ff"});
        vecs.push_back('{1'b0, 1'b0, 16'h0FFE, 16'h0FFE, "load_0ffe"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0FFF, "inc_0ffe"});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h1000, "ripple_0fff"});

        foreach (vecs[k]) begin
            apply(vecs[k].lb, vecs[k].inc, vecs[k].bin);
            $display("vec %0d %s: lb=%b inc=%b in=%h bus=%h", k, vecs[k].name,
                     vecs[k].lb, vecs[k].inc, vecs[k].bin, bus_w);
            check(vecs[k].name, bus_w, vecs[k].exp);
        end

        // Asynchronous reset pulse between edges.
        load_bar = 1'b1;
        inc      = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_reset_immediate", bus_w, 16'h0000);
        #9 rst = 1'b0;
        #1 check("reset_release_no_edge", bus_w, 16'h0000);
        model_q = 16'h0000;
        $display("seq reset pulse: bus=%h", bus_w);

        // Reset held across an edge with a pending load, then the load lands.
        @(posedge clk);
        #1;
        load_bar = 1'b0;
        bus_in   = 16'h8FFF;
        #2 rst = 1'b1;
        #1 check("reset_with_load_pending", bus_w, 16'h0000);
        @(posedge clk);
        #1 check("reset_overrides_load", bus_w, 16'h0000);
        #2 rst = 1'b0;
        #1 check("released_before_edge", bus_w, 16'h0000);
        @(posedge clk);
        #1 check("load_after_reset", bus_w, 16'h8FFF);
        model_q = 16'h8FFF;
        $display("seq reset+load: bus=%h", bus_w);

        // Output enabled while loading: old value until the edge, new after.
        load_bar = 1'b0;
        bus_in   = 16'h1234;
        #3 check("old_q_before_edge", bus_w, 16'h8FFF);
        @(posedge clk);
        #1 check("new_q_after_edge", bus_w, 16'h1234);
        model_q = 16'h1234;
        $display("seq enable+load: bus=%h", bus_w);

        // Tri-state: with the DUT floating, the bench driver owns the bus.
        load_bar   = 1'b1;
        inc        = 1'b0;
        assert_bar = 1'b1;
        drv_en     = 1'b1;
        drv_val    = 16'hA5C3;
        #1 check("hiz_pattern_a", bus_w, 16'hA5C3);
        drv_val    = 16'h5A3C;
        #1 check("hiz_pattern_b", bus_w, 16'h5A3C);
        @(posedge clk);
        #1 check("hiz_across_edge", bus_w, 16'h5A3C);
        drv_en     = 1'b0;
        assert_bar = 1'b0;
        #1 check("q_after_toggle", bus_w, 16'h1234);
        $display("seq tri-state: bus=%h", bus_w);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 400; r++) begin
            logic        lb;
            logic        ii;
            logic [15:0] bin;
            logic [15:0] rnd;
            rnd = 16'($urandom);
            lb  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            ii  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            bin = ($urandom_range(0, 2) == 0) ? (rnd | 16'h0FFF) : rnd;
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #1 check("rand_async_reset", bus_w, 16'h0000);
                #2 rst = 1'b0;
                model_q = 16'h0000;
            end
            apply(lb, ii, bin);
            $display("rand %0d: lb=%b inc=%b in=%h bus=%h model=%h", r, lb, ii, bin, bus_w, model_q);
            check("rand", bus_w, model_q);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
